// File: rtl/load_ext_pkg.sv
// load_ext_pkg: size encodings, occupancy states and the select/extend function for load_ext_unit.
package load_ext_pkg;
  localparam int MAX_W = 128;
  localparam int MAX_OFF_W = $clog2(MAX_W / 8);
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} occ_t;
  // Works on a MAX_W-wide container so one function serves every DATA_W up to MAX_W.
  function automatic logic [MAX_W:0] ext_result(input logic [MAX_W-1:0] data, input logic [MAX_OFF_W-1:0] off,
                                                input logic [1:0] size, input logic sext);
    logic [MAX_W-1:0] lane;
    logic err;
    lane = data >> {off, 3'b000};
    err = size == 2'b11 || (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != '0);
    return err ? {1'b1, {MAX_W{1'b0}}} :
           size == SZ_BYTE ? {1'b0, {(MAX_W-8){sext & lane[7]}}, lane[7:0]} :
           size == SZ_HALF ? {1'b0, {(MAX_W-16){sext & lane[15]}}, lane[15:0]} : {1'b0, data};
  endfunction
endpackage

// File: rtl/load_ext_unit_core.sv
// ext_core: combinational byte/half/word select and sign/zero extension with error flag.
module ext_core import load_ext_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              sext,
  output logic [DATA_W-1:0] value,
  output logic              err
);
  logic [MAX_W:0] r;
  assign r = ext_result(MAX_W'(data), MAX_OFF_W'(off), size, sext);
  assign value = r[DATA_W-1:0];
  assign err = r[MAX_W];
  if (DATA_W < MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^r[MAX_W-1:DATA_W];
  end
endmodule

// File: rtl/load_ext_unit.sv
// load_ext_unit: load-data extender with a 2-entry FIFO output buffer; LOAD_EXT_ERR_CNT_EN adds a saturating err_cnt.
module load_ext_unit import load_ext_pkg::*; #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [OFF_W-1:0]  in_off,
  input  logic [1:0]        in_size,
  input  logic              in_sext,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef LOAD_EXT_ERR_CNT_EN
  output logic [15:0]       err_cnt,
`endif
  output logic              out_err
);
  occ_t state, nxt;
  logic push, pop, c_err, hd_err, tl_err;
  logic [DATA_W-1:0] c_val, hd, tl;
  ext_core #(.DATA_W(DATA_W)) u_core (
    .data(in_data), .off(in_off), .size(in_size), .sext(in_sext), .value(c_val), .err(c_err)
  );
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign out_valid = state != ST_EMPTY;
  assign out_data = hd;
  assign out_err = hd_err;
  always_comb begin
    nxt = state;
    nxt = state == ST_EMPTY ? (push ? ST_ONE : ST_EMPTY) :
          state == ST_ONE ? (push && !pop ? ST_TWO : !push && pop ? ST_EMPTY : ST_ONE) :
          (pop ? ST_ONE : ST_TWO);
  end
  // in_ready is registered from the next state so it never depends combinationally on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_EMPTY;
      in_ready <= 1'b0;
    end else begin
      state <= nxt;
      in_ready <= nxt != ST_TWO;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hd <= '0;
      hd_err <= 1'b0;
      tl <= '0;
      tl_err <= 1'b0;
    end else begin
      if (state == ST_TWO && pop) begin
        hd <= tl;
        hd_err <= tl_err;
      end else if (push && (state == ST_EMPTY || pop)) begin
        hd <= c_val;
        hd_err <= c_err;
      end
      if (push && state == ST_ONE && !pop) begin
        tl <= c_val;
        tl_err <= c_err;
      end
    end
  end
`ifdef LOAD_EXT_ERR_CNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (push && c_err && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
  end
  assign err_cnt = cnt;
`endif
endmodule

// File: tb/tb_load_ext_unit.sv
// tb_load_ext_unit: randomized and directed self-checking bench for load_ext_unit against an arithmetic model.
module tb_load_ext_unit;
  logic clk = 0, rst = 1, in_valid = 0, in_sext = 0, out_ready = 0;
  logic in_ready, out_valid, out_err;
  logic [31:0] in_data = 0, out_data;
  logic [1:0] in_off = 0, in_size = 0;
`ifdef LOAD_EXT_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif
  int n_chk = 0, n_pass = 0, pops = 0, e_cnt = 0;
  logic [32:0] q[$];
  logic [32:0] sb_exp, sb_m;

  always #5 clk = ~clk;

  load_ext_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_off(in_off),
    .in_size(in_size), .in_sext(in_sext), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef LOAD_EXT_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .out_err(out_err)
  );

  function automatic logic [32:0] model(logic [31:0] d, int off, int size, bit sext);
    int w;
    longint lane;
    w = size == 0 ? 8 : size == 1 ? 16 : 32;
    if (size == 3 || off % (w / 8) != 0) return {1'b1, 32'h0};
    if (w == 32) return {1'b0, d};
    lane = (longint'(d) >> (8 * off)) % (longint'(1) << w);
    if (sext && lane >= (longint'(1) << (w - 1))) lane -= longint'(1) << w;
    return {1'b0, lane[31:0]};
  endfunction

  // Scoreboard: every consumed result must match the oldest accepted request.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      e_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        n_chk++;
        if (q.size() == 0) $display("FAIL sb_unexpected: got %h with nothing outstanding", {out_err, out_data});
        else begin
          sb_exp = q.pop_front();
          if ({out_err, out_data} !== sb_exp) $display("FAIL sb_order: got %h want %h", {out_err, out_data}, sb_exp);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) begin
        sb_m = model(in_data, int'(in_off), int'(in_size), in_sext);
        q.push_back(sb_m);
        if (sb_m[32] && e_cnt < 65535) e_cnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rand;
    in_data = $urandom;
    in_off = 2'($urandom_range(0, 3));
    in_size = 2'($urandom_range(0, 3));
    in_sext = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    rst = 1; in_valid = 1; in_data = 32'hDEAD_BEEF;
    repeat (2) tick;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_data !== 32'h0) $display("FAIL rst_out_data: got %h want 0", out_data); else n_pass++;
    n_chk++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %b want 0", out_err); else n_pass++;
    rst = 0; in_valid = 0;
    tick;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b want 1", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL post_rst_out_valid: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_errors;
    logic [1:0] so[3] = '{2'd1, 2'd2, 2'd0};
    logic [1:0] ss[3] = '{2'b01, 2'b10, 2'b11};
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 32'h1234_5678; in_off = so[i]; in_size = ss[i]; in_sext = 1;
      tick;
      n_chk++; if (out_err !== 1'b1) $display("FAIL err_flag[%0d]: got %b want 1", i, out_err); else n_pass++;
      n_chk++; if (out_data !== 32'h0) $display("FAIL err_data[%0d]: got %h want 0", i, out_data); else n_pass++;
    end
    in_valid = 0;
    tick;
`ifdef LOAD_EXT_ERR_CNT_EN
    n_chk++; if (err_cnt !== 16'd3) $display("FAIL err_cnt3: got %0d want 3", err_cnt); else n_pass++;
`endif
  endtask

  task automatic test_directed;
    logic [31:0] d[6] = '{32'h80FF_1234, 32'h80FF_1234, 32'h8000_0000, 32'h8000_0000, 32'h0000_FFFF, 32'h1234_5678};
    logic [1:0] o[6] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd0, 2'd0};
    logic [1:0] s[6] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10};
    logic x[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] e[6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_FFFF, 32'h1234_5678};
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; in_data = d[i]; in_off = o[i]; in_size = s[i]; in_sext = x[i];
      tick;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL dir_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_chk++; if ({out_err, out_data} !== {1'b0, e[i]}) $display("FAIL dir_data[%0d]: got %b/%h want 0/%h", i, out_err, out_data, e[i]); else n_pass++;
    end
    in_valid = 0;
    tick;
  endtask

  task automatic test_backpressure;
    logic [32:0] a;
    int p0;
    bit acc;
    out_ready = 0; in_valid = 1;
    set_rand; a = model(in_data, int'(in_off), int'(in_size), in_sext);
    tick;
    set_rand;
    tick;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL bp_full_valid: got %b want 1", out_valid); else n_pass++;
    set_rand;
    repeat (3) begin
      tick;
      n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_hold_ready: got %b want 0", in_ready); else n_pass++;
      n_chk++; if ({out_err, out_data} !== a) $display("FAIL bp_hold_data: got %h want %h", {out_err, out_data}, a); else n_pass++;
    end
    p0 = pops; out_ready = 1; acc = 0;
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick;
    end
    in_valid = 0;
    n_chk++; if (acc !== 1'b1) $display("FAIL bp_third_accept: got %b want 1", acc); else n_pass++;
    repeat (4) tick;
    n_chk++; if (pops - p0 !== 3) $display("FAIL bp_pop_count: got %0d want 3", pops - p0); else n_pass++;
    n_chk++; if (q.size() !== 0) $display("FAIL bp_left: got %0d want 0", q.size()); else n_pass++;
  endtask

  task automatic test_throughput;
    logic [32:0] e;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; set_rand; e = model(in_data, int'(in_off), int'(in_size), in_sext);
      tick;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL tp_ready[%0d]: got %b want 1", i, in_ready); else n_pass++;
      n_chk++; if (out_valid !== 1'b1) $display("FAIL tp_valid[%0d]: got %b want 1", i, out_valid); else n_pass++;
      n_chk++; if ({out_err, out_data} !== e) $display("FAIL tp_data[%0d]: got %h want %h", i, {out_err, out_data}, e); else n_pass++;
    end
    in_valid = 0;
    tick;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL tp_drained: got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = $urandom_range(0, 3) != 0;
      set_rand;
      tick;
    end
    in_valid = 0; out_ready = 1;
    repeat (4) tick;
    n_chk++; if (q.size() !== 0) $display("FAIL rnd_left: got %0d want 0", q.size()); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rnd_drained: got %b want 0", out_valid); else n_pass++;
`ifdef LOAD_EXT_ERR_CNT_EN
    n_chk++; if (err_cnt !== 16'(e_cnt)) $display("FAIL rnd_err_cnt: got %0d want %0d", err_cnt, e_cnt); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    int p0;
    out_ready = 0; in_valid = 1;
    set_rand; tick;
    set_rand; tick;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rm_full: got %b want 0", in_ready); else n_pass++;
    rst = 1;
    tick;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rm_valid: got %b want 0", out_valid); else n_pass++;
    n_chk++; if (in_ready !== 1'b0) $display("FAIL rm_ready: got %b want 0", in_ready); else n_pass++;
    n_chk++; if (out_data !== 32'h0) $display("FAIL rm_data: got %h want 0", out_data); else n_pass++;
    rst = 0; in_valid = 0;
    tick;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL rm_ready_after: got %b want 1", in_ready); else n_pass++;
    p0 = pops; out_ready = 1;
    repeat (3) begin
      tick;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rm_stale: got %b want 0", out_valid); else n_pass++;
    end
    n_chk++; if (pops !== p0) $display("FAIL rm_pops: got %0d want %0d", pops, p0); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_errors;
    test_directed;
    test_backpressure;
    test_throughput;
    test_random;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
